// File: rtl/rv32i_bpred_pkg.sv
// bpred_pkg: shared types and helpers for the rv32i_bpred branch predictor.
//   bpred_ctr_t   2-bit saturating direction counter (SNT, WNT, WT, ST)
//   bpred_entry_t one BTB entry (valid, tag, target, ctr)
//   ctr_next      saturating counter step for a resolved outcome
package bpred_pkg;

    // Entry fields are sized for the widest supported XLEN; narrower tags are
    // zero-extended by the predictor before they are stored or compared.
    localparam int unsigned BPRED_XLEN_MAX = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bpred_ctr_t;

    typedef struct packed {
        logic                      valid;
        logic [BPRED_XLEN_MAX-1:0] tag;
        logic [BPRED_XLEN_MAX-1:0] target;
        bpred_ctr_t                ctr;
    } bpred_entry_t;

    // Saturating step: ST stays ST on taken, SNT stays SNT on not-taken.
    function automatic bpred_ctr_t ctr_next(input bpred_ctr_t ctr, input logic taken);
        bpred_ctr_t r_next;
        r_next = ctr;
        case (ctr)
            SNT: r_next = taken ? WNT : SNT;
            WNT: r_next = taken ? WT  : SNT;
            WT:  r_next = taken ? ST  : WNT;
            ST:  r_next = taken ? ST  : WT;
            default: r_next = WNT;
        endcase
        return r_next;
    endfunction

endpackage

// File: rtl/rv32i_bpred.sv
// rv32i_bpred: direct-mapped BTB with 2-bit counters for the RV32I fetch stage.
// Fetch looks up combinationally with f_pc; execute trains it one cycle later.
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   f_pc                  fetch PC to predict
//   f_pred_taken          redirect fetch to f_pred_target (combinational)
//   f_pred_target         predicted next PC (combinational)
//   e_upd_valid/pc/taken/jump/target  resolved control transfer from execute
//   e_upd_mispredict      wrong-prediction flag, only consumed by the stats build
// Optional feature: define RV_BPRED_STATS_EN to add stat_branches and
// stat_mispredicts (32-bit wrapping event counters).
module rv32i_bpred
    import bpred_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    output logic [XLEN-1:0] f_pred_target,
    input  logic            e_upd_valid,
    input  logic [XLEN-1:0] e_upd_pc,
    input  logic            e_upd_taken,
    input  logic            e_upd_jump,
    input  logic [XLEN-1:0] e_upd_target,
    input  logic            e_upd_mispredict
`ifdef RV_BPRED_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rv32i_bpred: DEPTH must be a power of two and >= 2");
    end
    if (XLEN > BPRED_XLEN_MAX) begin : g_bad_xlen
        $error("rv32i_bpred: XLEN exceeds entry field width");
    end

    bpred_entry_t     r_btb [DEPTH];

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    bpred_entry_t     w_f_ent;
    bpred_entry_t     w_u_ent;
    bpred_entry_t     w_u_new;
    logic             w_f_hit;
    logic             w_u_hit;
    logic             w_wr_en;

    // Byte-offset bits never affect index or tag; mispredict is stats-only.
    logic             w_unused_bits;
    assign w_unused_bits = ^{f_pc[1:0], e_upd_pc[1:0], e_upd_mispredict};

    assign w_f_idx = f_pc[IDX_W+1:2];
    assign w_f_tag = f_pc[XLEN-1:IDX_W+2];
    assign w_u_idx = e_upd_pc[IDX_W+1:2];
    assign w_u_tag = e_upd_pc[XLEN-1:IDX_W+2];

    // Lookup: reads the stored array, so a same-cycle update is not bypassed.
    always_comb begin
        w_f_ent       = r_btb[w_f_idx];
        w_f_hit       = w_f_ent.valid && (w_f_ent.tag == BPRED_XLEN_MAX'(w_f_tag));
        f_pred_taken  = w_f_hit && w_f_ent.ctr[1];
        f_pred_target = w_f_hit ? w_f_ent.target[XLEN-1:0] : f_pc + XLEN'(4);
    end

    // Training: decide whether and what to write into the indexed slot.
    always_comb begin
        w_wr_en = 1'b0;
        w_u_ent = r_btb[w_u_idx];
        w_u_hit = w_u_ent.valid && (w_u_ent.tag == BPRED_XLEN_MAX'(w_u_tag));
        w_u_new = w_u_ent;
        if (e_upd_valid) begin
            if (e_upd_jump) begin
                w_wr_en = 1'b1;
                w_u_new = '{valid: 1'b1, tag: BPRED_XLEN_MAX'(w_u_tag),
                            target: BPRED_XLEN_MAX'(e_upd_target), ctr: ST};
            end else if (w_u_hit) begin
                w_wr_en     = 1'b1;
                w_u_new.ctr = ctr_next(w_u_ent.ctr, e_upd_taken);
                if (e_upd_taken) begin
                    w_u_new.target = BPRED_XLEN_MAX'(e_upd_target);
                end
            end else if (e_upd_taken) begin
                // Miss on a taken branch evicts whatever occupied the slot.
                w_wr_en = 1'b1;
                w_u_new = '{valid: 1'b1, tag: BPRED_XLEN_MAX'(w_u_tag),
                            target: BPRED_XLEN_MAX'(e_upd_target), ctr: WT};
            end
        end
    end

    // BTB storage; reset wins over any update in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (w_wr_en) begin
            r_btb[w_u_idx] <= w_u_new;
        end
    end

`ifdef RV_BPRED_STATS_EN
    // Event counters, wrapping modulo 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (e_upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (e_upd_mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_bpred.sv
// tb_rv32i_bpred: directed self-checking bench for rv32i_bpred (DEPTH=64).
module tb_rv32i_bpred;

    logic        clock;
    logic        reset_n;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic [31:0] f_pred_target;
    logic        e_upd_valid;
    logic [31:0] e_upd_pc;
    logic        e_upd_taken;
    logic        e_upd_jump;
    logic [31:0] e_upd_target;
    logic        e_upd_mispredict;
`ifdef RV_BPRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rv32i_bpred #(.XLEN(32), .DEPTH(64)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .f_pc             (f_pc),
        .f_pred_taken     (f_pred_taken),
        .f_pred_target    (f_pred_target),
        .e_upd_valid      (e_upd_valid),
        .e_upd_pc         (e_upd_pc),
        .e_upd_taken      (e_upd_taken),
        .e_upd_jump       (e_upd_jump),
        .e_upd_target     (e_upd_target),
        .e_upd_mispredict (e_upd_mispredict)
`ifdef RV_BPRED_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One training update across one rising edge; inputs change 1ns after the edge.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic jp,
                       input logic [31:0] tgt, input logic mis);
        e_upd_valid      = 1'b1;
        e_upd_pc         = pc;
        e_upd_taken      = tk;
        e_upd_jump       = jp;
        e_upd_target     = tgt;
        e_upd_mispredict = mis;
        @(posedge clock);
        #1;
        e_upd_valid      = 1'b0;
        e_upd_mispredict = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_tgt);
        f_pc = pc;
        #1;
        check({tag, "_taken"}, 32'(f_pred_taken), 32'(exp_tk));
        check({tag, "_target"}, f_pred_target, exp_tgt);
    endtask

    initial begin
        reset_n          = 1'b0;
        f_pc             = 32'h100;
        e_upd_valid      = 1'b0;
        e_upd_pc         = '0;
        e_upd_taken      = 1'b0;
        e_upd_jump       = 1'b0;
        e_upd_target     = '0;
        e_upd_mispredict = 1'b0;

        look("reset", 32'h100, 1'b0, 32'h104);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Allocate on taken miss, then hysteresis down to SNT and back up.
        upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
        look("alloc", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
        look("hyst_wnt", 32'h100, 1'b0, 32'h80);
        upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
        upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
        look("hyst_snt", 32'h100, 1'b0, 32'h80);
        upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
        look("hyst_up_wnt", 32'h100, 1'b0, 32'h80);
        upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
        look("hyst_up_wt", 32'h100, 1'b1, 32'h80);

        // Jump at 0x200 shares index 0 with 0x100 and evicts it.
        upd(32'h200, 1'b0, 1'b1, 32'h40, 1'b0);
        look("jump_hit", 32'h200, 1'b1, 32'h40);
        look("jump_evict", 32'h100, 1'b0, 32'h104);
        upd(32'h200, 1'b0, 1'b0, 32'h999, 1'b0);
        look("jump_nt_wt", 32'h200, 1'b1, 32'h40);

        // Saturation at ST, then step down twice.
        upd(32'h200, 1'b1, 1'b0, 32'h44, 1'b0);
        upd(32'h200, 1'b1, 1'b0, 32'h44, 1'b0);
        upd(32'h200, 1'b0, 1'b0, 32'h44, 1'b0);
        look("sat_st_wt", 32'h200, 1'b1, 32'h44);
        upd(32'h200, 1'b0, 1'b0, 32'h44, 1'b0);
        look("sat_wnt", 32'h200, 1'b0, 32'h44);

        // Aliasing between 0x100 and 0x200.
        upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
        look("alias_a_hit", 32'h100, 1'b1, 32'h80);
        look("alias_b_miss", 32'h200, 1'b0, 32'h204);
        upd(32'h200, 1'b1, 1'b0, 32'h60, 1'b0);
        look("alias_b_hit", 32'h200, 1'b1, 32'h60);
        look("alias_a_miss", 32'h100, 1'b0, 32'h104);

        // Not-taken misses never allocate.
        upd(32'h300, 1'b0, 1'b0, 32'h70, 1'b0);
        look("nt_miss_keep", 32'h200, 1'b1, 32'h60);
        look("nt_miss_noalloc", 32'h300, 1'b0, 32'h304);
        upd(32'h104, 1'b0, 1'b0, 32'h70, 1'b0);
        look("nt_miss_idx1", 32'h104, 1'b0, 32'h108);

        // Fields without e_upd_valid must not train.
        e_upd_pc     = 32'h400;
        e_upd_taken  = 1'b1;
        e_upd_target = 32'h20;
        @(posedge clock);
        #1;
        look("no_valid", 32'h400, 1'b0, 32'h404);

        // Same-cycle lookup and update: old entry, then new one after the edge.
        f_pc             = 32'h200;
        e_upd_valid      = 1'b1;
        e_upd_pc         = 32'h200;
        e_upd_taken      = 1'b0;
        e_upd_jump       = 1'b1;
        e_upd_target     = 32'h10;
        #1;
        check("collide_old_taken", 32'(f_pred_taken), 32'd1);
        check("collide_old_target", f_pred_target, 32'h60);
        @(posedge clock);
        #1;
        e_upd_valid = 1'b0;
        e_upd_jump  = 1'b0;
        look("collide_new", 32'h200, 1'b1, 32'h10);

        // Mid-run reset with a concurrent update: effect is immediate, update dropped.
        e_upd_valid  = 1'b1;
        e_upd_pc     = 32'h104;
        e_upd_taken  = 1'b1;
        e_upd_target = 32'h30;
        reset_n      = 1'b0;
        look("rst_async", 32'h200, 1'b0, 32'h204);
        @(posedge clock);
        #1;
        e_upd_valid = 1'b0;
        look("rst_drop_upd", 32'h104, 1'b0, 32'h108);
        look("rst_q100", 32'h100, 1'b0, 32'h104);
`ifdef RV_BPRED_STATS_EN
        check("stat_branches_rst", stat_branches, 32'd0);
        check("stat_mispredicts_rst", stat_mispredicts, 32'd0);
`endif
        reset_n = 1'b1;

        // Five updates, two flagged as mispredicts.
        upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b1);
        look("post_rst_alloc", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
        upd(32'h104, 1'b0, 1'b0, 32'h90, 1'b0);
        upd(32'h208, 1'b0, 1'b1, 32'h50, 1'b1);
        upd(32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
        look("post_stats_st_wt", 32'h100, 1'b1, 32'h80);
        look("post_stats_jump", 32'h208, 1'b1, 32'h50);
`ifdef RV_BPRED_STATS_EN
        check("stat_branches", stat_branches, 32'd5);
        check("stat_mispredicts", stat_mispredicts, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
